// File: rtl/rob_pkg.sv
// Shared types for the reorder-buffer allocation responder.
//   rob_entry_t : one ROB slot (status bits + booking payload)
//   rob_tag_t   : entry index, rob_ptr_t : index plus wrap bit
// Payload field widths follow AREG_W_DEF / PREG_W_DEF. The top-level
// width parameters default to these values and are expected to match them.
package rob_pkg;

  localparam int ROB_DEPTH_DEF = 16;
  localparam int AREG_W_DEF    = 5;
  localparam int PREG_W_DEF    = 6;
  localparam int TAG_W_DEF     = $clog2(ROB_DEPTH_DEF);

  typedef logic [TAG_W_DEF-1:0] rob_tag_t;
  typedef logic [TAG_W_DEF:0]   rob_ptr_t;

  typedef struct packed {
    logic                  valid;
    logic                  done;
    logic                  has_dst;
    logic [AREG_W_DEF-1:0] areg;
    logic [PREG_W_DEF-1:0] preg;
    logic [PREG_W_DEF-1:0] old_preg;
  } rob_entry_t;

endpackage

// File: rtl/rob_wrap_ptr.sv
// Wrap-bit pointer: W-1 index bits plus an MSB that toggles on each lap,
// so equal/opposite MSBs tell empty from full.
//   clk : clock
//   clr : synchronous clear to 0 (wins over inc)
//   inc : advance by one
//   ptr : current pointer value
module rob_wrap_ptr #(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] ptr
);

  always_ff @(posedge clk) begin
    if (clr)      ptr <= '0;
    else if (inc) ptr <= ptr + 1'b1;
  end

endmodule

// File: rtl/rob_alloc_resp.sv
// Reorder-buffer allocation responder. Books entries in order from the
// register manager, marks them done from the writeback broadcast and
// retires them in program order to the commit director.
//   clk, rst                 : clock, synchronous active-high reset
//   alloc_*                  : booking handshake; alloc_tag = tail index
//   wb_valid, wb_tag         : completion broadcast
//   commit_valid/ready       : head retirement handshake
//   commit_has_dst/areg/preg/free_preg : head entry fields
//   flush                    : discard all entries
//   count, empty, full       : occupancy
module rob_alloc_resp
  import rob_pkg::*;
#(
  parameter int ROB_DEPTH = ROB_DEPTH_DEF,
  parameter int AREG_W    = AREG_W_DEF,
  parameter int PREG_W    = PREG_W_DEF,
  parameter int TAG_W     = $clog2(ROB_DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              alloc_valid,
  output logic              alloc_ready,
  input  logic              alloc_has_dst,
  input  logic [AREG_W-1:0] alloc_areg,
  input  logic [PREG_W-1:0] alloc_preg,
  input  logic [PREG_W-1:0] alloc_old_preg,
  output logic [TAG_W-1:0]  alloc_tag,
  input  logic              wb_valid,
  input  logic [TAG_W-1:0]  wb_tag,
  output logic              commit_valid,
  input  logic              commit_ready,
  output logic              commit_has_dst,
  output logic [AREG_W-1:0] commit_areg,
  output logic [PREG_W-1:0] commit_preg,
  output logic [PREG_W-1:0] commit_free_preg,
  input  logic              flush,
  output logic [TAG_W:0]    count,
  output logic              empty,
  output logic              full
);

  logic [TAG_W:0]   head_ptr, tail_ptr;
  logic [TAG_W-1:0] head_idx, tail_idx;
  logic             clr, alloc_fire, commit_fire;

  rob_entry_t ent [ROB_DEPTH];

  // Reset and flush share one path: both empty the buffer on the next edge.
  assign clr = rst | flush;

  rob_wrap_ptr #(.W(TAG_W+1)) u_head (
    .clk(clk), .clr(clr), .inc(commit_fire), .ptr(head_ptr)
  );
  rob_wrap_ptr #(.W(TAG_W+1)) u_tail (
    .clk(clk), .clr(clr), .inc(alloc_fire), .ptr(tail_ptr)
  );

  assign head_idx = head_ptr[TAG_W-1:0];
  assign tail_idx = tail_ptr[TAG_W-1:0];

  assign empty = (head_ptr == tail_ptr);
  assign full  = (head_ptr[TAG_W-1:0] == tail_ptr[TAG_W-1:0]) &&
                 (head_ptr[TAG_W] != tail_ptr[TAG_W]);
  assign count = tail_ptr - head_ptr;

  // Depends only on registered state and rst/flush, never on the
  // handshake inputs, so a commit cannot open a slot in the same cycle.
  assign alloc_ready = !full && !clr;
  assign alloc_fire  = alloc_valid && alloc_ready;
  assign alloc_tag   = tail_idx;

  assign commit_valid     = !empty && ent[head_idx].done && !clr;
  assign commit_fire      = commit_valid && commit_ready;
  assign commit_has_dst   = ent[head_idx].has_dst;
  assign commit_areg      = ent[head_idx].areg;
  assign commit_preg      = ent[head_idx].preg;
  assign commit_free_preg = ent[head_idx].old_preg;

  // Head and tail indices can only coincide when empty or full, where
  // commit or allocate respectively is blocked, so those two never collide.
  // Allocation is written last so it wins over a same-tag writeback.
  always_ff @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < ROB_DEPTH; i++) begin
        ent[i].valid <= 1'b0;
        ent[i].done  <= 1'b0;
      end
    end else begin
      if (wb_valid && ent[wb_tag].valid) ent[wb_tag].done <= 1'b1;
      if (commit_fire) ent[head_idx].valid <= 1'b0;
      if (alloc_fire) begin
        ent[tail_idx].valid    <= 1'b1;
        ent[tail_idx].done     <= 1'b0;
        ent[tail_idx].has_dst  <= alloc_has_dst;
        ent[tail_idx].areg     <= alloc_areg;
        ent[tail_idx].preg     <= alloc_preg;
        ent[tail_idx].old_preg <= alloc_old_preg;
      end
    end
  end

endmodule
